// File: rtl/sram_matrix_loader.sv
// sram_matrix_loader: streams a header plus row-major matrix elements into SRAM,
// rejecting empty matrices and any that would run past the top of the address space.
module sram_matrix_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_address,
    output logic              load_ready,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] sram_write_address,
    output logic [31:0]       sram_write_data,
    output logic              load_done,
    output logic              load_error
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HEADER = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;
    localparam logic [63:0] ADDR_MAX = (64'd1 << ADDR_W) - 64'd1;
    logic [2:0]        state;
    logic [ADDR_W-1:0] base;
    logic [31:0]       total;
    logic [31:0]       count;
    logic [31:0]       hdr_total;
    logic [63:0]       hdr_end;
    logic              hdr_bad;
    assign load_ready = state == IDLE;
    assign s_ready    = state == HEADER || state == DATA;
    assign load_done  = state == DONE;
    assign load_error = state == ERROR;
    assign hdr_total  = 32'(s_data[31:16]) * 32'(s_data[15:0]);
    // Wide sum so the end-of-matrix check cannot itself wrap.
    assign hdr_end    = 64'(base) + 64'(hdr_total);
    assign hdr_bad    = s_data[31:16] == 16'd0 || s_data[15:0] == 16'd0 || hdr_end > ADDR_MAX;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= IDLE;
            base               <= '0;
            total              <= '0;
            count              <= '0;
            sram_write_enable  <= 1'b0;
            sram_write_address <= '0;
            sram_write_data    <= '0;
        end else begin
            sram_write_enable <= 1'b0;
            case (state)
                IDLE: if (load_start) begin
                    base  <= base_address;
                    state <= HEADER;
                end
                HEADER: if (s_valid) begin
                    total <= hdr_total;
                    if (hdr_bad) state <= ERROR;
                    else begin
                        count              <= '0;
                        sram_write_enable  <= 1'b1;
                        sram_write_address <= base;
                        sram_write_data    <= s_data;
                        state              <= DATA;
                    end
                end
                DATA: if (s_valid) begin
                    sram_write_enable  <= 1'b1;
                    sram_write_address <= base + ADDR_W'(count) + ADDR_W'(1);
                    sram_write_data    <= s_data;
                    count              <= count + 32'd1;
                    if (count == total - 32'd1) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_matrix_loader.sv
// tb_sram_matrix_loader: randomized and directed loads checked against an
// address/data/cycle list computed from the header arithmetic.
module tb_sram_matrix_loader;
    localparam int AW = 12;
    logic          clk = 1'b0;
    logic          reset_n;
    logic          load_start;
    logic [AW-1:0] base_address;
    logic          load_ready;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          sram_write_enable;
    logic [AW-1:0] sram_write_address;
    logic [31:0]   sram_write_data;
    logic          load_done;
    logic          load_error;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int w_addr[$];
    logic [31:0] w_data[$];
    int w_cyc[$];
    int x_cyc[$];
    int done_cyc[$];
    int err_cyc[$];
    bit pulse_prev = 1'b0;
    sram_matrix_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .load_start(load_start), .base_address(base_address),
        .load_ready(load_ready), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
        .sram_write_data(sram_write_data), .load_done(load_done), .load_error(load_error)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sram_write_enable) begin
            w_addr.push_back(int'(sram_write_address));
            w_data.push_back(sram_write_data);
            w_cyc.push_back(cyc);
        end
        if (load_done) done_cyc.push_back(cyc);
        if (load_error) err_cyc.push_back(cyc);
        if (pulse_prev && reset_n) check("ready_after_pulse", load_ready, 1);
        pulse_prev = load_done || load_error;
    end
    task automatic clear_logs();
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        x_cyc.delete(); done_cyc.delete(); err_cyc.delete();
    endtask
    task automatic push(input logic [31:0] d, input int bub);
        repeat (bub) begin
            s_valid = 1'b0; s_data = $urandom;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d;
        for (int i = 0; i < 50 && !s_ready; i++) begin @(posedge clk); #1; end
        if (!s_ready) check("s_ready_timeout", 0, 1);
        x_cyc.push_back(cyc);
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = $urandom;
    endtask
    task automatic start(input int base);
        s_valid = 1'b1; s_data = $urandom;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("ready_idle", load_ready, 1);
        load_start = 1'b1; base_address = AW'(base);
        @(posedge clk); #1;
        load_start = 1'b0; base_address = AW'($urandom);
    endtask
    task automatic run_load(input int base, input logic [31:0] hdr, input int mode, input bit busy, input bit fixed);
        longint rows = longint'(hdr[31:16]);
        longint cols = longint'(hdr[15:0]);
        longint total = rows * cols;
        bit bad = rows == 0 || cols == 0 || longint'(base) + total > 4095;
        int ea[$];
        logic [31:0] ed[$];
        logic [31:0] d;
        clear_logs();
        start(base);
        push(hdr, 0);
        if (!bad) begin
            ea.push_back(base); ed.push_back(hdr);
            for (int i = 0; i < int'(total); i++) begin
                d = fixed ? 32'hA + 32'(i) : $urandom;
                ea.push_back(base + 1 + i); ed.push_back(d);
                if (busy && i == 1) begin load_start = 1'b1; base_address = AW'(100); end
                push(d, mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 2)));
                load_start = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("n_writes", w_addr.size(), ea.size());
        for (int i = 0; i < ea.size() && i < w_addr.size(); i++) begin
            check("wr_addr", w_addr[i], ea[i]);
            check("wr_data", w_data[i], ed[i]);
            check("wr_cycle", w_cyc[i], x_cyc[i] + 1);
        end
        if (bad) begin
            check("n_error", err_cyc.size(), 1);
            check("n_done_on_error", done_cyc.size(), 0);
            if (err_cyc.size() > 0) check("error_cycle", err_cyc[0], x_cyc[0] + 1);
        end else begin
            check("n_done", done_cyc.size(), 1);
            check("n_error_on_ok", err_cyc.size(), 0);
            if (done_cyc.size() > 0 && w_cyc.size() > 0) check("done_with_last", done_cyc[0], w_cyc[w_cyc.size()-1]);
        end
        check("ready_end", load_ready, 1);
    endtask
    task automatic reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_we"}, sram_write_enable, 0);
        check({tag, "_addr"}, sram_write_address, 0);
        check({tag, "_data"}, sram_write_data, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_error"}, load_error, 0);
        check({tag, "_ready"}, load_ready, 1);
    endtask
    initial begin
        logic [31:0] hdr;
        int base;
        reset_n = 1'b0; load_start = 1'b0; base_address = '0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_outputs("reset");
        reset_n = 1'b1;
        run_load(0, 32'h0002_0003, 0, 0, 1);
        if (w_cyc.size() == 7) check("b2b_span", w_cyc[6] - w_cyc[0], 6);
        if (w_data.size() == 7) check("b2b_last_data", w_data[6], 32'hF);
        run_load(0, 32'h0002_0003, 1, 0, 1);
        run_load(0, 32'h0000_0005, 0, 0, 0);
        run_load(4090, 32'h0002_0004, 0, 0, 0);
        run_load(4087, 32'h0002_0004, 0, 0, 0);
        if (w_addr.size() > 0) check("boundary_last_addr", w_addr[w_addr.size()-1], 4095);
        run_load(1, 32'h0001_0001, 0, 0, 0);
        run_load(20, 32'h0003_0002, 2, 1, 0);
        // Reset while loading: the word transferred in the reset cycle must never be written.
        clear_logs();
        start(32'h200);
        push(32'h0002_0003, 0);
        for (int i = 0; i < 3; i++) push(32'h100 + 32'(i), 0);
        s_valid = 1'b1; s_data = 32'hDEAD;
        reset_n = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        reset_outputs("mid_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_n_writes", w_addr.size(), 4);
        if (w_addr.size() == 4) check("rst_last_addr", w_addr[3], 32'h203);
        check("rst_no_done", done_cyc.size(), 0);
        check("rst_ready", load_ready, 1);
        for (int k = 0; k < 40; k++) begin
            hdr = {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))};
            if ($urandom_range(0, 9) == 0) hdr = $urandom;
            base = $urandom_range(0, 3) == 0 ? int'($urandom_range(4070, 4095)) : int'($urandom_range(0, 4095));
            run_load(base, hdr, int'($urandom_range(0, 2)), 1'($urandom), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_matrix_loader.md
SRAM_MATRIX_LOADER -- requirements
Module: sram_matrix_loader

Interface
REQ-001 Parameter: ADDR_W, default 12, SRAM address width; data width is fixed at 32.
REQ-002 clk  input  1  single clock; all logic is on the rising edge.
REQ-003 reset_n  input  1  reset; synchronous, active-low.
REQ-004 load_start  input  1  single-cycle request to begin loading one matrix; sampled only in IDLE.
REQ-005 base_address  input  ADDR_W  SRAM address for the header word; latched with load_start.
REQ-006 load_ready  output  1  high only in IDLE.
REQ-007 s_valid  input  1  stream word valid.
REQ-008 s_data  input  32  stream word: the header first, then elements in row-major order.
REQ-009 s_ready  output  1  loader accepts a stream word this cycle.
REQ-010 sram_write_enable  output  1  one-cycle SRAM write strobe.
REQ-011 sram_write_address  output  ADDR_W  SRAM write address.
REQ-012 sram_write_data  output  32  SRAM write data.
REQ-013 load_done  output  1  one-cycle pulse: matrix fully written.
REQ-014 load_error  output  1  one-cycle pulse: header rejected.

Function
REQ-015 Header format: rows = s_data[31:16], cols = s_data[15:0]; this is the same layout the MAC reads from address 0.
REQ-016 A transfer occurs in any cycle with s_valid && s_ready; no other cycle consumes s_data.
REQ-017 States: IDLE, HEADER, DATA, DONE, ERROR.
REQ-018 IDLE behaviour:
- load_ready=1, s_ready=0.
- On load_start, latch base_address and go to HEADER.
REQ-019 HEADER behaviour: s_ready=1; on a transfer, compute total = rows*cols (32-bit).
REQ-020 Header check: if rows==0, cols==0, or base_address+total > 2^ADDR_W-1 (evaluated without truncation), go to ERROR and write nothing.
REQ-021 Otherwise go to DATA, write the header word at base_address, and clear the element counter to 0.
REQ-022 DATA behaviour:
- s_ready=1.
- Each transfer writes s_data at base_address+1+count, then increments count.
- The transfer with count==total-1 moves to DONE.
REQ-023 DONE: s_ready=0, load_done=1 for exactly one cycle, then go to IDLE.
REQ-024 ERROR: s_ready=0, load_error=1 for exactly one cycle, then go to IDLE.
REQ-025 Write outputs are registered: a transfer in cycle t drives write_enable/address/data in cycle t+1 only.
REQ-026 Write-enable timing:
- write_enable is 0 in every cycle not following an accepted header or element transfer.
- address and data hold their last value when write_enable is 0.
REQ-027 The last element's write is asserted in the same cycle as load_done.
REQ-028 Stream bubbles (s_valid=0) in HEADER or DATA stall the FSM; no timeout.
REQ-029 load_start outside IDLE is ignored; base_address is not re-latched.
REQ-030 Stream words presented in IDLE, DONE or ERROR are not consumed.
REQ-031 Addresses never wrap; the overflow check of REQ-020 guarantees every write address is at most 2^ADDR_W-1.
REQ-032 A 1x1 matrix goes through DATA for exactly one transfer.

Reset
REQ-033 With reset_n=0 at a rising edge, the next state is IDLE regardless of the current state.
REQ-034 Output reset values: s_ready=0, sram_write_enable=0, sram_write_address=0, sram_write_data=0, load_done=0, load_error=0, load_ready=1.
REQ-035 Internal reset values: counter, latched base and total all 0.
REQ-036 A write pending from the transfer in the reset cycle is discarded.
REQ-037 After reset_n returns to 1, the block behaves as freshly idle; a partially loaded matrix is not resumed.

Verification
REQ-038 Back-to-back load: base=0, load_start, then header 0x0002_0003 and words 0xA..0xF with s_valid held high. Required response:
- writes (0,0x00020003), (1,0xA) .. (6,0xF) in 7 consecutive cycles;
- load_done coincides with the write to address 6;
- load_ready returns the following cycle.
REQ-039 Bubbles: same load with s_valid low on alternate cycles -> identical write sequence, no write_enable in bubble-following cycles, load_done on the last write.
REQ-040 Zero dimension: header 0x0000_0005 -> no writes, load_error for one cycle after the header transfer, IDLE on the next cycle.
REQ-041 Overflow: base=4090 (ADDR_W=12), header 0x0002_0004 -> load_error, zero writes. Boundary: base=4087, same header -> accepted, last write at address 4095.
REQ-042 Reset during DATA: reset_n low after the 3rd element transfer -> no further writes, all outputs at reset values, load_ready=1 after reset is released.
REQ-043 Start while busy: load_start pulsed with base=100 during DATA -> ignored; remaining writes continue from the original base.
